// File: rtl/nnet_acc_relu_24s_if.sv
// Product stream in, requantized activation out.
// Valid/ready handshakes on both sides plus the quasi-static bias.
interface nnet_acc_relu_24s_if #(
    parameter int OUT_W = 8
);
    logic signed [23:0] prod_dat;
    logic               prod_vld;
    logic               prod_rdy;
    logic signed [23:0] bias;
    logic [OUT_W-1:0]   res_dat;
    logic               res_vld;
    logic               res_rdy;

    modport master (
        output prod_dat, prod_vld, bias, res_rdy,
        input  prod_rdy, res_dat, res_vld
    );

    modport slave (
        input  prod_dat, prod_vld, bias, res_rdy,
        output prod_rdy, res_dat, res_vld
    );
endinterface

// File: rtl/nnet_acc_relu_24s.sv
// Bias + dot-product accumulator with round-half-up shift,
// ReLU and saturation to an unsigned OUT_W-bit activation.
module nnet_acc_relu_24s #(
    parameter int N_IN  = 25,
    parameter int SHIFT = 4,
    parameter int OUT_W = 8
) (
    input logic                    ap_clk,
    input logic                    ap_rst,
    nnet_acc_relu_24s_if.slave     io
);
    localparam int CNT_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic signed [31:0] RND =
        (SHIFT > 0) ? (32'sd1 <<< (SHIFT - 1)) : 32'sd0;
    localparam logic signed [31:0] MAXV =
        (32'sd1 <<< OUT_W) - 32'sd1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IN - 1);

    typedef enum logic {
        ACC,
        OUT
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic signed [31:0] acc_q, acc_d;
    logic [OUT_W-1:0]   res_q, res_d;

    logic               accept;
    logic               last;
    logic signed [31:0] base;
    logic signed [31:0] sum;
    logic signed [31:0] rq;
    logic [OUT_W-1:0]   act;

    assign accept = (state_q == ACC) && io.prod_vld;
    assign last   = (cnt_q == LAST);
    // First term of a group starts from bias instead of the old sum.
    assign base   = (cnt_q == '0) ? 32'(io.bias) : acc_q;
    assign sum    = base + 32'(io.prod_dat);
    assign rq     = (sum + RND) >>> SHIFT;

    always_comb begin
        act = '0;
        if (rq < 0)
            act = '0;
        else if (rq > MAXV)
            act = '1;
        else
            act = rq[OUT_W-1:0];
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        res_d   = res_q;
        unique case (state_q)
            ACC: begin
                if (accept) begin
                    acc_d = sum;
                    if (last) begin
                        cnt_d   = '0;
                        res_d   = act;
                        state_d = OUT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            OUT: begin
                if (io.res_rdy)
                    state_d = ACC;
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            state_q <= ACC;
            cnt_q   <= '0;
            acc_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            res_q   <= res_d;
        end
    end

    assign io.prod_rdy = (state_q == ACC);
    assign io.res_vld  = (state_q == OUT);
    assign io.res_dat  = res_q;
endmodule

// File: tb/tb_nnet_acc_relu_24s.sv
// Directed-vector bench for nnet_acc_relu_24s with
// N_IN=4, SHIFT=2, OUT_W=8.
module tb_nnet_acc_relu_24s;
    localparam int N_IN  = 4;
    localparam int SHIFT = 2;
    localparam int OUT_W = 8;

    logic ap_clk = 1'b0;
    logic ap_rst = 1'b1;

    int n_vec = 0;
    int n_bad = 0;

    nnet_acc_relu_24s_if #(.OUT_W(OUT_W)) bus ();

    nnet_acc_relu_24s #(
        .N_IN (N_IN),
        .SHIFT(SHIFT),
        .OUT_W(OUT_W)
    ) dut (
        .ap_clk(ap_clk),
        .ap_rst(ap_rst),
        .io    (bus.slave)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic chk(input string tag,
                       input longint got,
                       input longint exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d",
                     tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    // Feeds one 4-term group; result must appear one cycle after
    // the 4th accept and clear one cycle later (res_rdy held 1).
    task automatic run_group(input string tag,
                             input int b,
                             input int p0, input int p1,
                             input int p2, input int p3,
                             input bit bubbles,
                             input int exp);
        int p[4];
        p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
        bus.bias = 24'(b);
        for (int i = 0; i < 4; i++) begin
            chk({tag, "_rdy"}, longint'(bus.prod_rdy), 1);
            bus.prod_vld = 1'b1;
            bus.prod_dat = 24'(p[i]);
            tick();
            bus.prod_vld = 1'b0;
            bus.prod_dat = 24'hABCDEF;
            if (i < 3) begin
                chk({tag, "_early"}, longint'(bus.res_vld), 0);
                if (bubbles) begin
                    tick();
                    chk({tag, "_bub"}, longint'(bus.res_vld), 0);
                end
            end
        end
        chk({tag, "_vld"}, longint'(bus.res_vld), 1);
        chk({tag, "_dat"}, longint'(bus.res_dat), longint'(exp));
        chk({tag, "_stall"}, longint'(bus.prod_rdy), 0);
        tick();
        chk({tag, "_drop"}, longint'(bus.res_vld), 0);
    endtask

    initial begin
        bus.prod_dat = '0;
        bus.prod_vld = 1'b0;
        bus.bias     = '0;
        bus.res_rdy  = 1'b1;
        ap_rst = 1'b1;
        tick();
        tick();
        ap_rst = 1'b0;
        chk("rst_rdy", longint'(bus.prod_rdy), 1);
        chk("rst_vld", longint'(bus.res_vld), 0);
        chk("rst_dat", longint'(bus.res_dat), 0);

        run_group("b2b", 0, 10, 20, 30, 40, 1'b0, 25);
        run_group("relu", -200, 10, 20, 30, 40, 1'b0, 0);
        run_group("sat", 0, 8388607, 8388607,
                  8388607, 8388607, 1'b0, 255);
        run_group("bubble", 0, 10, 20, 30, 40, 1'b1, 25);
        run_group("neg", 1000, -100, -100, -100, -100, 1'b0, 150);
        // (6+2)>>>2 = 2: exact half rounds up
        run_group("half", 3, 1, 1, 1, 0, 1'b0, 2);
        run_group("rnddn", 0, 9, 0, 0, 0, 1'b0, 2);
        run_group("negsmall", 0, -6, 0, 0, 0, 1'b0, 0);
        run_group("maxok", 1020, 0, 0, 0, 0, 1'b0, 255);
        run_group("justover", 1022, 0, 0, 0, 0, 1'b0, 255);
        run_group("mid", 1017, 0, 0, 0, 0, 1'b0, 254);

        // Backpressure: result held, input blocked.
        bus.res_rdy = 1'b0;
        bus.bias = 24'(0);
        for (int i = 0; i < 4; i++) begin
            bus.prod_vld = 1'b1;
            bus.prod_dat = 24'(10 * (i + 1));
            tick();
        end
        bus.prod_dat = 24'(999);
        for (int i = 0; i < 3; i++) begin
            chk("hold_vld", longint'(bus.res_vld), 1);
            chk("hold_dat", longint'(bus.res_dat), 25);
            chk("hold_rdy", longint'(bus.prod_rdy), 0);
            tick();
        end
        bus.prod_vld = 1'b0;
        bus.res_rdy = 1'b1;
        chk("hold_last", longint'(bus.res_dat), 25);
        tick();
        chk("rel_rdy", longint'(bus.prod_rdy), 1);
        chk("rel_vld", longint'(bus.res_vld), 0);
        run_group("after_hold", 0, 4, 8, 12, 16, 1'b0, 10);

        // Mid-group reset discards partial sum.
        bus.bias = 24'(500);
        for (int i = 0; i < 2; i++) begin
            bus.prod_vld = 1'b1;
            bus.prod_dat = 24'(100);
            tick();
        end
        bus.prod_vld = 1'b0;
        ap_rst = 1'b1;
        tick();
        ap_rst = 1'b0;
        chk("mrst_rdy", longint'(bus.prod_rdy), 1);
        chk("mrst_vld", longint'(bus.res_vld), 0);
        chk("mrst_dat", longint'(bus.res_dat), 0);
        run_group("post_rst", 0, 4, 4, 4, 4, 1'b0, 4);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_vec, n_bad);
        $finish;
    end
endmodule
